// File: rtl/mbscore_bus_arbiter_pkg.sv
// Shared constants for the MBScore RAM-port arbiter: default widths,
// FSM state encodings and the encoding of the outstanding read's owner.
package mbscore_bus_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/mbscore_bus_arbiter_prio.sv
// Winner select for the shared RAM port: data beats inst. With
// MBS_BUS_STARVE_GUARD_EN a run of STARVE_MAX data grants against a waiting fetch forces one inst grant.
module mbscore_bus_prio #(
  parameter int STARVE_MAX = 4
) (
`ifdef MBS_BUS_STARVE_GUARD_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic i_arb_en,
  input  logic i_inst_req,
  input  logic i_data_req,
  output logic o_win_inst,
  output logic o_win_data
);

`ifdef MBS_BUS_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_force_inst;

  assign w_force_inst = i_inst_req && (r_starve_cnt >= CW'(STARVE_MAX));
  assign o_win_data   = i_arb_en && i_data_req && !w_force_inst;
  assign o_win_inst   = i_arb_en && i_inst_req && !o_win_data;

  // Only data grants that leave a fetch waiting extend the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (o_win_inst) begin
      r_starve_cnt <= '0;
    end else if (o_win_data) begin
      if (!i_inst_req)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != CW'(STARVE_MAX))
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign o_win_data = i_arb_en && i_data_req;
  assign o_win_inst = i_arb_en && i_inst_req && !i_data_req;
`endif

endmodule

// File: rtl/mbscore_bus_arbiter.sv
// Sequences MBScore's single RAM port between fetch and load/store, one access
// outstanding. Optional starvation guard: define MBS_BUS_STARVE_GUARD_EN.
module mbscore_bus_arbiter
  import mbscore_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_gnt,
  output logic                  inst_rvalid,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int LAT_W = 2;

  logic [0:0]            r_state;
  logic [LAT_W-1:0]      r_lat_cnt;
  owner_e                r_owner;
  logic                  r_inst_rvalid;
  logic                  r_data_rvalid;
  logic [DATA_WIDTH-1:0] r_inst_rdata;
  logic [DATA_WIDTH-1:0] r_data_rdata;

  logic w_arb_en;
  logic w_win_inst;
  logic w_win_data;
  logic w_ram_re;
  logic w_ram_we;

  // Gating with rst_n keeps every strobe low while reset is held.
  assign w_arb_en = rst_n && (r_state == ST_IDLE);

  mbscore_bus_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
`ifdef MBS_BUS_STARVE_GUARD_EN
    .clk        (clk),
    .rst_n      (rst_n),
`endif
    .i_arb_en   (w_arb_en),
    .i_inst_req (inst_req),
    .i_data_req (data_req),
    .o_win_inst (w_win_inst),
    .o_win_data (w_win_data)
  );

  assign w_ram_we = w_win_data && data_we;
  assign w_ram_re = w_win_inst || (w_win_data && !data_we);

  assign inst_gnt    = w_win_inst;
  assign data_gnt    = w_win_data;
  assign ram_re      = w_ram_re;
  assign ram_we      = w_ram_we;
  assign ram_addr    = w_win_data ? data_addr : (w_win_inst ? inst_addr : '0);
  assign ram_wdata   = w_ram_we ? data_wdata : '0;
  assign inst_rvalid = r_inst_rvalid;
  assign data_rvalid = r_data_rvalid;
  assign inst_rdata  = r_inst_rdata;
  assign data_rdata  = r_data_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_lat_cnt     <= '0;
      r_owner       <= OWN_NONE;
      r_inst_rvalid <= 1'b0;
      r_data_rvalid <= 1'b0;
      r_inst_rdata  <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_inst_rvalid <= 1'b0;
      r_data_rvalid <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_ram_we) begin
          r_data_rvalid <= 1'b1;
        end else if (w_ram_re) begin
          r_state   <= ST_RD_WAIT;
          r_owner   <= w_win_inst ? OWN_INST : OWN_DATA;
          r_lat_cnt <= LAT_W'(RAM_LAT - 1);
        end
      end else if (r_lat_cnt == '0) begin
        // ram_rdata is valid now; an ownerless wait just falls back to IDLE.
        r_state <= ST_IDLE;
        r_owner <= OWN_NONE;
        if (r_owner == OWN_INST) begin
          r_inst_rdata  <= ram_rdata;
          r_inst_rvalid <= 1'b1;
        end else if (r_owner == OWN_DATA) begin
          r_data_rdata  <= ram_rdata;
          r_data_rvalid <= 1'b1;
        end
      end else begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/mbscore_bus_arbiter.md
Name: mbscore_bus_arbiter

Overview:
Sequences the single shared RAM port of MBScore between the instruction-fetch requester and the load/store requester. Uses a registered req/gnt/rvalid handshake with one outstanding access at a time. Read data is captured into per-requester registers, so no tri-state or level-sensitive latch is needed. Sits between the core's fetch/LSU stages and the RAM, replacing direct address/strobe muxing.

Parameters:
DATA_WIDTH, 32, RAM data width.
ADDR_WIDTH, 32, RAM address width.
RAM_LAT, 1, RAM read latency in cycles (legal range 1..4); ram_rdata is valid RAM_LAT cycles after the ram_re cycle.
STARVE_MAX, 4, consecutive data grants tolerated while inst_req is pending (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst_req  in  1  fetch request; held with inst_addr stable until inst_gnt
inst_addr  in  ADDR_WIDTH  fetch address
inst_gnt  out  1  one-cycle accept pulse for fetch
inst_rvalid  out  1  one-cycle fetch data valid
inst_rdata  out  DATA_WIDTH  fetch data, held until next inst_rvalid
data_req  in  1  load/store request; held with its qualifiers stable until data_gnt
data_we  in  1  1 = store, 0 = load
data_addr  in  ADDR_WIDTH  load/store address
data_wdata  in  DATA_WIDTH  store data
data_gnt  out  1  one-cycle accept pulse for load/store
data_rvalid  out  1  one-cycle load data valid, or store ack
data_rdata  out  DATA_WIDTH  load data, held until next load completion
ram_addr  out  ADDR_WIDTH  RAM address
ram_re  out  1  RAM read strobe
ram_we  out  1  RAM write strobe
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lat counter=0, owner=none, starve counter=0.
  - All gnt, rvalid, ram_re and ram_we outputs = 0.
  - inst_rdata, data_rdata, ram_addr and ram_wdata = 0.
- States are IDLE and RD_WAIT.
- IDLE, grant cycle T:
  - If any request is pending, pick the winner. Default priority: data over inst.
  - Assert the winner's gnt, drive ram_addr (and ram_wdata for a store), and assert ram_re or ram_we. All of these are combinational from the request in cycle T and last one cycle.
  - The loser keeps waiting; its gnt stays 0.
- Read grant at T (fetch or load):
  - Go to RD_WAIT and record the owner.
  - The counter tracks RAM_LAT.
  - On the edge ending cycle T+RAM_LAT, capture ram_rdata into the owner's rdata register.
  - The owner's rvalid is high in cycle T+RAM_LAT+1; return to IDLE.
  - A new grant is allowed in that same rvalid cycle, so read throughput is one access per RAM_LAT+1 cycles.
- Store grant at T:
  - Stay in IDLE.
  - data_rvalid pulses in T+1; data_rdata is unchanged.
  - A new grant is allowed in T+1.
- RD_WAIT: no gnt, ram_re=0, ram_we=0. Requests arriving now are held off.
- ram_addr and ram_wdata are 0 when no strobe is active.
- Requests deasserted before gnt are protocol violations; behaviour is undefined, but the FSM must never hang.
- rst_n asserted mid-read: the access is discarded, no rvalid is issued, and the block is in IDLE after release.
- Simultaneous inst_req and data_req in IDLE: data is granted. Fetch is granted at the next IDLE opportunity if data_req has dropped.

Optional Feature:
Macro MBS_BUS_STARVE_GUARD_EN.
- Defined:
  - Count consecutive data grants issued while inst_req=1.
  - When the count reaches STARVE_MAX, the next IDLE arbitration grants inst even if data_req=1.
  - The counter clears on any inst grant, or on a data grant while inst_req=0.
- Not defined: strict data priority, no counter logic, and STARVE_MAX is ignored.

Decomposition:
- Shared package/const include:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - FSM state encodings (IDLE, RD_WAIT).
  - Owner encoding (OWN_NONE, OWN_INST, OWN_DATA).
- One natural sub-module, mbscore_bus_prio: combinational winner select plus the optional starvation counter. The FSM and capture registers remain in the top.

Test Plan:
- Reset: rst_n=0 mid-operation -> all outputs 0 immediately; after release there is no stray rvalid.
- Single fetch, RAM_LAT=1: inst_req addr 0x100 at T, RAM returns 0xDEADBEEF in T+1 -> inst_gnt and ram_re in T with ram_addr=0x100; inst_rvalid in T+2 with inst_rdata=0xDEADBEEF.
- Collision: inst_req and data_req (load 0x200) both at T -> data_gnt at T; inst_gnt at T+2 (RAM_LAT=1); data_rvalid in T+2; inst_rvalid in T+4.
- Store: data_we=1, addr 0x40, wdata 0x12345678 at T -> ram_we=1, ram_addr=0x40, ram_wdata=0x12345678 in T; data_rvalid in T+1; data_rdata unchanged.
- Latency sweep with RAM_LAT=3: load at T -> no grants during T+1..T+3; data_rvalid in T+4 with the correct data.
- MBS_BUS_STARVE_GUARD_EN, STARVE_MAX=4: data_req held continuously (stores) with inst_req=1 -> exactly 4 data grants, then an inst grant, then data resumes.
